// File: rtl/vz_pkg.sv
// Shared constants and state encoding for the VZ snapshot uploader.
package vz_pkg;

   localparam int unsigned VZ_HDR_LEN  = 24;
   localparam int unsigned VZ_NAME_LEN = 17;
   localparam int unsigned VZ_NAME_OFS = 4;
   localparam int unsigned VZ_TYPE_OFS = VZ_NAME_OFS + VZ_NAME_LEN;

   localparam logic [7:0] VZ_TYPE_BASIC  = 8'hF0;
   localparam logic [7:0] VZ_TYPE_BINARY = 8'hF1;

   // Magic "VZF0", first file byte in the top byte lane.
   localparam logic [31:0] VZ_MAGIC = 32'h565A_4630;
   // Program name "MISTER", first character in the top byte lane.
   localparam logic [47:0] VZ_NAME  = 48'h4D49_5354_4552;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PTR_LO,
      ST_PTR_HI,
      ST_CALC,
      ST_READY,
      ST_FETCH,
      ST_DONE
   } vz_state_e;

endpackage

// File: rtl/vz_header_rom.sv
// Constant 24-byte VZ header, indexed by file offset; offsets 24..31 read as zero.
module vz_header_rom
   import vz_pkg::*;
#(
   parameter logic [15:0] BASIC_START = 16'h7AE9,
   parameter logic [7:0]  FILE_TYPE   = VZ_TYPE_BASIC
) (
   input  logic [4:0] offset,
   output logic [7:0] data_c
);

   always_comb begin
      data_c = 8'h00;
      case (offset)
         5'd0:  data_c = VZ_MAGIC[31:24];
         5'd1:  data_c = VZ_MAGIC[23:16];
         5'd2:  data_c = VZ_MAGIC[15:8];
         5'd3:  data_c = VZ_MAGIC[7:0];
         5'd4:  data_c = VZ_NAME[47:40];
         5'd5:  data_c = VZ_NAME[39:32];
         5'd6:  data_c = VZ_NAME[31:24];
         5'd7:  data_c = VZ_NAME[23:16];
         5'd8:  data_c = VZ_NAME[15:8];
         5'd9:  data_c = VZ_NAME[7:0];
         5'd21: data_c = FILE_TYPE;
         5'd22: data_c = BASIC_START[7:0];
         5'd23: data_c = BASIC_START[15:8];
         default: data_c = 8'h00;
      endcase
   end

endmodule

// File: rtl/vz_uploader.sv
// Serves a VZ snapshot of the BASIC program area to the HPS upload path,
// generating the header locally and fetching program bytes through the RAM arbiter.
module vz_uploader
   import vz_pkg::*;
#(
   parameter logic [15:0] BASIC_START  = 16'h7AE9,
   parameter logic [15:0] END_PTR_ADDR = 16'h78F9,
   parameter logic [7:0]  FILE_TYPE    = VZ_TYPE_BASIC
) (
   input  logic        CLK10MHZ,
   input  logic        RESET,
   input  logic        upload_arm,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [15:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic [15:0] upload_size,
   output logic        ready,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data
);

   localparam logic [15:0] HDR_LEN16 = 16'(VZ_HDR_LEN);

   vz_state_e   state;
   logic [15:0] end_ptr;
   logic        upload_q;
   logic        drop_pending;

   logic [7:0]  hdr_byte_c;
   logic        is_hdr_c;
   logic        in_range_c;
   logic        upload_fall_c;
   logic [15:0] fetch_addr_c;
   logic [15:0] span_c;
   logic [16:0] sum_c;
   logic [15:0] size_c;

   vz_header_rom #(
      .BASIC_START (BASIC_START),
      .FILE_TYPE   (FILE_TYPE)
   ) u_hdr (
      .offset (ioctl_addr[4:0]),
      .data_c (hdr_byte_c)
   );

   assign is_hdr_c      = ioctl_addr < HDR_LEN16;
   assign in_range_c    = ioctl_addr < upload_size;
   assign upload_fall_c = upload_q & ~ioctl_upload;
   assign fetch_addr_c  = BASIC_START + (ioctl_addr - HDR_LEN16);

   // File size: header plus program span, saturating at 16 bits.
   assign span_c = end_ptr - BASIC_START;
   assign sum_c  = 17'(span_c) + 17'(VZ_HDR_LEN);
   assign size_c = (end_ptr <= BASIC_START) ? HDR_LEN16 :
                   (sum_c[16] ? 16'hFFFF : sum_c[15:0]);

   always_ff @(posedge CLK10MHZ or negedge RESET) begin
      if (!RESET) begin
         state        <= ST_IDLE;
         end_ptr      <= 16'h0000;
         upload_q     <= 1'b0;
         drop_pending <= 1'b0;
         ioctl_din    <= 8'h00;
         ioctl_wait   <= 1'b0;
         upload_size  <= 16'h0000;
         ready        <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= 16'h0000;
      end else begin
         upload_q <= ioctl_upload;
         case (state)
            ST_IDLE, ST_DONE: begin
               // Arm takes priority over any read seen in the same cycle.
               if (upload_arm) begin
                  ready    <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_addr <= END_PTR_ADDR;
                  state    <= ST_PTR_LO;
               end
            end
            ST_PTR_LO: begin
               if (mem_ack) begin
                  end_ptr[7:0] <= mem_data;
                  mem_addr     <= END_PTR_ADDR + 16'd1;
                  state        <= ST_PTR_HI;
               end
            end
            ST_PTR_HI: begin
               if (mem_ack) begin
                  end_ptr[15:8] <= mem_data;
                  mem_req       <= 1'b0;
                  state         <= ST_CALC;
               end
            end
            ST_CALC: begin
               upload_size <= size_c;
               ready       <= 1'b1;
               state       <= ST_READY;
            end
            ST_READY: begin
               if (upload_fall_c) begin
                  state <= ST_DONE;
               end else if (ioctl_rd && ioctl_upload) begin
                  if (is_hdr_c) begin
                     ioctl_din <= hdr_byte_c;
                  end else if (in_range_c) begin
                     mem_req      <= 1'b1;
                     mem_addr     <= fetch_addr_c;
                     ioctl_wait   <= 1'b1;
                     drop_pending <= 1'b0;
                     state        <= ST_FETCH;
                  end else begin
                     ioctl_din <= 8'h00;
                  end
               end
            end
            ST_FETCH: begin
               // A window close during the fetch still completes the handshake.
               if (upload_fall_c) begin
                  drop_pending <= 1'b1;
               end
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  ioctl_wait <= 1'b0;
                  if (drop_pending || upload_fall_c) begin
                     state <= ST_DONE;
                  end else begin
                     ioctl_din <= mem_data;
                     state     <= ST_READY;
                  end
               end
            end
            default: begin
               mem_req    <= 1'b0;
               ioctl_wait <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vz_uploader.sv
// Scoreboard bench for vz_uploader with a behavioural RAM arbiter of programmable ack delay.
module tb_vz_uploader;
   import vz_pkg::*;

   logic        clk;
   logic        RESET;
   logic        upload_arm;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [15:0] upload_size;
   logic        ready;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;

   bit   [7:0]  mem [0:65535];
   int          ack_delay;
   logic        rd_chk;
   logic [7:0]  exp_q [$];

   int n_pass;
   int n_total;

   vz_uploader dut (
      .CLK10MHZ     (clk),
      .RESET        (RESET),
      .upload_arm   (upload_arm),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .upload_size  (upload_size),
      .ready        (ready),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_data     (mem_data)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_total++;
      $display("FAIL %s: timed out", name);
   endtask

   // Arbiter: acks on the ack_delay-th falling edge that sees mem_req high.
   initial begin
      int acnt;
      acnt     = 0;
      mem_ack  = 1'b0;
      mem_data = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            acnt++;
            if (acnt >= ack_delay) begin
               mem_ack  = 1'b1;
               mem_data = mem[mem_addr];
               acnt     = 0;
            end else begin
               mem_ack = 1'b0;
            end
         end else begin
            mem_ack = 1'b0;
            acnt    = 0;
         end
      end
   end

   // Monitor: after each checked read, wait for ioctl_wait low and compare.
   initial begin
      int w;
      forever begin
         @(posedge clk iff (ioctl_rd && rd_chk));
         w = 0;
         @(negedge clk);
         while (ioctl_wait && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (ioctl_wait) note_fail("rd_wait");
         else if (exp_q.size() == 0) note_fail("rd_unexpected");
         else chk("rd_data", 32'(ioctl_din), 32'(exp_q.pop_front()));
      end
   end

   task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input bit check,
                          input logic [15:0] exp_addr,
                          output int wcnt, output bit req_seen, output bit addr_bad);
      @(negedge clk);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      rd_chk     = check;
      if (check) exp_q.push_back(exp);
      @(negedge clk);
      ioctl_rd = 1'b0;
      rd_chk   = 1'b0;
      wcnt     = 0;
      req_seen = mem_req;
      addr_bad = 1'b0;
      while (ioctl_wait && wcnt < 50) begin
         if (mem_req) begin
            req_seen = 1'b1;
            if (mem_addr !== exp_addr) addr_bad = 1'b1;
         end
         wcnt++;
         @(negedge clk);
      end
   endtask

   task automatic arm(input bit with_rd, output int cyc);
      @(negedge clk);
      upload_arm = 1'b1;
      if (with_rd) begin
         ioctl_addr = 16'd0;
         ioctl_rd   = 1'b1;
      end
      @(negedge clk);
      upload_arm = 1'b0;
      ioctl_rd   = 1'b0;
      cyc = 0;
      while (!ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic set_ptr(input logic [15:0] p);
      mem[16'h78F9] = p[7:0];
      mem[16'h78FA] = p[15:8];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  cyc;
      int  w;
      bit  rs;
      bit  ab;
      n_pass       = 0;
      n_total      = 0;
      RESET        = 1'b0;
      upload_arm   = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = 16'h0000;
      rd_chk       = 1'b0;
      ack_delay    = 1;

      repeat (3) @(negedge clk);
      chk("rst_din",   32'(ioctl_din),   32'h0);
      chk("rst_wait",  32'(ioctl_wait),  32'h0);
      chk("rst_size",  32'(upload_size), 32'h0);
      chk("rst_ready", 32'(ready),       32'h0);
      chk("rst_req",   32'(mem_req),     32'h0);
      chk("rst_addr",  32'(mem_addr),    32'h0);
      chk("rst_state", 32'(dut.state),   32'(ST_IDLE));
      RESET = 1'b1;

      // Program ends at 7B00: 23 program bytes plus the header.
      set_ptr(16'h7B00);
      mem[16'h7AE9] = 8'h12;
      mem[16'h7AEA] = 8'h34;
      mem[16'h7AFF] = 8'h5C;
      arm(1'b0, cyc);
      chk("arm_latency", 32'(cyc), 32'd3);
      chk("size_47", 32'(upload_size), 32'd47);
      chk("ready_1", 32'(ready), 32'd1);

      ioctl_upload = 1'b1;
      do_read(16'd0,  8'h56, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd1,  8'h5A, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd2,  8'h46, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd3,  8'h30, 1'b1, 16'h0, w, rs, ab);
      chk("hdr_no_wait", 32'(w), 32'd0);
      do_read(16'd4,  8'h4D, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd10, 8'h00, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd21, 8'hF0, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd22, 8'hE9, 1'b1, 16'h0, w, rs, ab);
      do_read(16'd23, 8'h7A, 1'b1, 16'h0, w, rs, ab);

      do_read(16'd24, 8'h12, 1'b1, 16'h7AE9, w, rs, ab);
      chk("fetch0_wait", 32'(w), 32'd1);
      chk("fetch0_addr", 32'(ab), 32'd0);

      ack_delay = 5;
      do_read(16'd25, 8'h34, 1'b1, 16'h7AEA, w, rs, ab);
      chk("fetch5_wait", 32'(w), 32'd5);
      chk("fetch5_addr", 32'(ab), 32'd0);
      ack_delay = 1;
      do_read(16'd47, 8'h00, 1'b1, 16'h0, w, rs, ab);
      chk("past_end_noreq", 32'(rs), 32'd0);
      do_read(16'd46, 8'h5C, 1'b1, 16'h7AFF, w, rs, ab);

      @(negedge clk);
      ioctl_upload = 1'b0;
      repeat (2) @(negedge clk);
      chk("state_done", 32'(dut.state), 32'(ST_DONE));
      chk("done_ready", 32'(ready), 32'd1);
      chk("done_size", 32'(upload_size), 32'd47);

      // End pointer below the program start; arm coincides with a read.
      set_ptr(16'h7000);
      ioctl_upload = 1'b1;
      arm(1'b1, cyc);
      chk("arm_rd_latency", 32'(cyc), 32'd3);
      chk("arm_rd_din", 32'(ioctl_din), 32'h5C);
      chk("size_24", 32'(upload_size), 32'd24);
      do_read(16'd24, 8'h00, 1'b1, 16'h0, w, rs, ab);
      chk("empty_noreq", 32'(rs), 32'd0);
      do_read(16'd5, 8'h49, 1'b1, 16'h0, w, rs, ab);

      // Window closes while a slow fetch is outstanding.
      @(negedge clk);
      ioctl_upload = 1'b0;
      set_ptr(16'h7B00);
      repeat (2) @(negedge clk);
      ioctl_upload = 1'b1;
      arm(1'b0, cyc);
      do_read(16'd0, 8'h56, 1'b1, 16'h0, w, rs, ab);
      ack_delay = 5;
      @(negedge clk);
      ioctl_addr = 16'd24;
      ioctl_rd   = 1'b1;
      @(negedge clk);
      ioctl_rd = 1'b0;
      @(negedge clk);
      ioctl_upload = 1'b0;
      w = 0;
      while (ioctl_wait && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (ioctl_wait) note_fail("drop_wait");
      chk("drop_state", 32'(dut.state), 32'(ST_DONE));
      chk("drop_din", 32'(ioctl_din), 32'h56);
      chk("drop_req", 32'(mem_req), 32'd0);

      // Asynchronous reset in the middle of a fetch.
      ioctl_upload = 1'b1;
      arm(1'b0, cyc);
      @(negedge clk);
      ioctl_addr = 16'd25;
      ioctl_rd   = 1'b1;
      @(negedge clk);
      ioctl_rd = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", 32'(mem_req), 32'd1);
      RESET = 1'b0;
      #1;
      chk("midrst_req",   32'(mem_req),     32'd0);
      chk("midrst_wait",  32'(ioctl_wait),  32'd0);
      chk("midrst_ready", 32'(ready),       32'd0);
      chk("midrst_size",  32'(upload_size), 32'd0);
      chk("midrst_din",   32'(ioctl_din),   32'd0);
      chk("midrst_addr",  32'(mem_addr),    32'd0);
      chk("midrst_state", 32'(dut.state),   32'(ST_IDLE));
      @(negedge clk);
      RESET     = 1'b1;
      ack_delay = 1;
      arm(1'b0, cyc);
      chk("rearm_latency", 32'(cyc), 32'd3);
      chk("rearm_size", 32'(upload_size), 32'd47);
      do_read(16'd24, 8'h12, 1'b1, 16'h7AE9, w, rs, ab);
      chk("rearm_wait", 32'(w), 32'd1);

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
